// File: rtl/bob_wport_arb_if.sv
// Bus bundle between the bob write-port arbiter and its writers / bob_ram write port.
// The slave modport is the arbiter's view; master is the writers' and RAM's view.
interface bob_wport_arb_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
);
  logic                    except;
  logic                    alloc_en;
  logic [ADDR_WIDTH-1:0]   alloc_addr;
  logic [DATA_WIDTH-1:0]   alloc_data;
  logic                    alloc_stall;
  logic [2:0]              upd_valid;
  logic [3*ADDR_WIDTH-1:0] upd_addr;
  logic [3*DATA_WIDTH-1:0] upd_data;
  logic [2:0]              upd_ready;
  logic [ADDR_WIDTH-1:0]   write_addr;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    write_wen;

  modport slave (
    input  except, alloc_en, alloc_addr, alloc_data, upd_valid, upd_addr, upd_data,
    output alloc_stall, upd_ready, write_addr, write_data, write_wen
  );

  modport master (
    output except, alloc_en, alloc_addr, alloc_data, upd_valid, upd_addr, upd_data,
    input  alloc_stall, upd_ready, write_addr, write_data, write_wen
  );
endinterface

// File: rtl/bob_wport_arb.sv
// Shares the single bob_ram write port between in-order allocation and three
// buffered out-of-order update requesters, with round-robin and anti-starvation.
module bob_wport_arb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  parameter int STARVE_LIM = 4
) (
  input logic           clk,
  input logic           rst,
  bob_wport_arb_if.slave bus
);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [2:0]    push, pop, nonempty, ready;
  logic [EW-1:0] head [3];

  logic          any_pend, found, stall;
  logic          alloc_grant, upd_grant;
  logic [1:0]    winner, cand, rr_ptr_q, rr_ptr_d;
  logic [2:0]    sum;
  logic [SW-1:0] starve_q, starve_d;
  logic [EW-1:0] sel_entry;

  logic                  write_wen_q;
  logic [ADDR_WIDTH-1:0] write_addr_q;
  logic [DATA_WIDTH-1:0] write_data_q;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
      logic [EW-1:0] mem_q [2];
      logic          wr_ptr_q, rd_ptr_q;
      logic [1:0]    cnt_q, cnt_d;

      // Ready comes from registered count only, so a same-cycle pop never frees a slot.
      assign ready[gi]    = (cnt_q < 2'd2);
      assign nonempty[gi] = (cnt_q != 2'd0);
      assign push[gi]     = bus.upd_valid[gi] && ready[gi] && !bus.except;
      assign pop[gi]      = upd_grant && (winner == 2'(gi));
      assign head[gi]     = mem_q[rd_ptr_q];

      always_comb begin
        cnt_d = cnt_q;
        case ({push[gi], pop[gi]})
          2'b10:   cnt_d = cnt_q + 2'd1;
          2'b01:   cnt_d = cnt_q - 2'd1;
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst || bus.except) begin
          cnt_q    <= 2'd0;
          wr_ptr_q <= 1'b0;
          rd_ptr_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          if (push[gi]) wr_ptr_q <= ~wr_ptr_q;
          if (pop[gi])  rd_ptr_q <= ~rd_ptr_q;
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi])
          mem_q[wr_ptr_q] <= {bus.upd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH],
                              bus.upd_data[gi*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  endgenerate

  assign any_pend    = |nonempty;
  assign stall       = (starve_q == SW'(STARVE_LIM));
  assign alloc_grant = bus.alloc_en && !stall && !bus.except;

  // First non-empty FIFO at or after rr_ptr, wrapping mod 3.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    sum    = 3'd0;
    cand   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      sum  = {1'b0, rr_ptr_q} + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && nonempty[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign upd_grant = !alloc_grant && found && !bus.except;
  assign sel_entry = alloc_grant ? {bus.alloc_addr, bus.alloc_data} : head[winner];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    starve_d = starve_q;
    if (upd_grant)
      rr_ptr_d = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
    if (upd_grant || !any_pend)
      starve_d = '0;
    else if (alloc_grant && !stall)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.except) begin
      rr_ptr_q <= 2'd0;
      starve_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
    end
  end

  // Address/data hold their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_wen_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      write_wen_q <= alloc_grant || upd_grant;
      if (alloc_grant || upd_grant) begin
        write_addr_q <= sel_entry[EW-1 -: ADDR_WIDTH];
        write_data_q <= sel_entry[DATA_WIDTH-1:0];
      end
    end
  end

  assign bus.alloc_stall = stall;
  assign bus.upd_ready   = ready;
  assign bus.write_wen   = write_wen_q;
  assign bus.write_addr  = write_addr_q;
  assign bus.write_data  = write_data_q;
endmodule

// File: tb/tb_bob_wport_arb.sv
// Self-checking bench for bob_wport_arb: directed scenarios feed a write-order
// scoreboard, while state-visible outputs are checked at fixed cycles.
module tb_bob_wport_arb;
  localparam int AW = 6;
  localparam int DW = 64;

  logic clk;
  logic rst;

  bob_wport_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bob_wport_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIM(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_idle();
    bus.except    = 1'b0;
    bus.alloc_en  = 1'b0;
    bus.upd_valid = 3'b000;
  endtask

  task automatic idle(input int n);
    drv_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drv_alloc(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = a;
    bus.alloc_data = d;
  endtask

  task automatic drv_upd(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.upd_valid[i]         = 1'b1;
    bus.upd_addr[i*AW +: AW] = a;
    bus.upd_data[i*DW +: DW] = d;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every RAM write must match the next expected entry in order.
  always @(negedge clk) begin
    if (bus.write_wen === 1'b1) begin
      $display("write addr=%0h data=%0h", bus.write_addr, bus.write_data);
      if (sb_q.size() == 0) begin
        chk("sb_extra_write", 64'(bus.write_wen), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wr_addr", 64'(bus.write_addr), 64'(e.a));
        chk("wr_data", bus.write_data, e.d);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    drv_idle();
    bus.alloc_addr = '0;
    bus.alloc_data = '0;
    bus.upd_addr   = '0;
    bus.upd_data   = '0;

    // Reset held two cycles, then one allocation.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_wen", 64'(bus.write_wen), 64'd0);
    chk("rst_waddr", 64'(bus.write_addr), 64'd0);
    chk("rst_ready", 64'(bus.upd_ready), 64'd7);
    chk("rst_stall", 64'(bus.alloc_stall), 64'd0);
    drv_alloc(6'd5, 64'hAA);
    expect_wr(6'd5, 64'hAA);
    tick();
    drv_idle();
    chk("alloc_wen", 64'(bus.write_wen), 64'd1);
    chk("alloc_addr", 64'(bus.write_addr), 64'd5);
    chk("alloc_data", bus.write_data, 64'hAA);
    idle(2);

    // Round-robin, twice: order 0,1,2 on consecutive cycles.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        drv_upd(i, 6'(10 + i), 64'(256 + 16 * r + i));
        expect_wr(6'(10 + i), 64'(256 + 16 * r + i));
      end
      tick();
      drv_idle();
      chk("rr_wen_push", 64'(bus.write_wen), 64'd0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("rr_wen_burst", 64'(bus.write_wen), 64'd1);
      end
      tick();
      chk("rr_wen_done", 64'(bus.write_wen), 64'd0);
    end
    idle(2);

    // Starvation: 4 alloc wins, one stall cycle, the update, then alloc resumes.
    drv_upd(1, 6'h31, 64'hDEAD);
    tick();
    drv_idle();
    for (int k = 0; k < 4; k++) begin
      drv_alloc(6'(32 + k), 64'(4096 + k));
      expect_wr(6'(32 + k), 64'(4096 + k));
      chk("starve_nostall", 64'(bus.alloc_stall), 64'd0);
      tick();
    end
    expect_wr(6'h31, 64'hDEAD);
    drv_alloc(6'd36, 64'd4100);
    expect_wr(6'd36, 64'd4100);
    chk("starve_stall", 64'(bus.alloc_stall), 64'd1);
    tick();
    chk("starve_stall_drop", 64'(bus.alloc_stall), 64'd0);
    tick();
    drv_alloc(6'd37, 64'd4101);
    expect_wr(6'd37, 64'd4101);
    chk("starve_resume", 64'(bus.alloc_stall), 64'd0);
    tick();
    idle(3);

    // FIFO full on requester 2 while allocation takes the port.
    drv_alloc(6'd40, 64'h500);
    expect_wr(6'd40, 64'h500);
    drv_upd(2, 6'd50, 64'h600);
    tick();
    drv_alloc(6'd41, 64'h501);
    expect_wr(6'd41, 64'h501);
    drv_upd(2, 6'd51, 64'h601);
    chk("full_ready_c1", 64'(bus.upd_ready[2]), 64'd1);
    tick();
    drv_alloc(6'd42, 64'h502);
    expect_wr(6'd42, 64'h502);
    drv_upd(2, 6'd52, 64'h602);
    chk("full_ready_c2", 64'(bus.upd_ready[2]), 64'd0);
    tick();
    bus.alloc_en = 1'b0;
    expect_wr(6'd50, 64'h600);
    expect_wr(6'd51, 64'h601);
    chk("full_ready_hold", 64'(bus.upd_ready[2]), 64'd0);
    tick();
    drv_idle();
    chk("full_ready_after_pop", 64'(bus.upd_ready[2]), 64'd1);
    idle(4);

    // Exception flush: move rr_ptr off 0, buffer 4 entries, then flush.
    drv_upd(0, 6'd1, 64'h700);
    expect_wr(6'd1, 64'h700);
    tick();
    idle(3);
    drv_alloc(6'd20, 64'h800);
    expect_wr(6'd20, 64'h800);
    for (int i = 0; i < 3; i++) drv_upd(i, 6'(60 + i), 64'(2304 + i));
    tick();
    bus.upd_valid = 3'b000;
    drv_alloc(6'd21, 64'h801);
    expect_wr(6'd21, 64'h801);
    drv_upd(0, 6'd63, 64'h903);
    tick();
    drv_alloc(6'd22, 64'h802);
    for (int i = 0; i < 3; i++) drv_upd(i, 6'(2 + i), 64'(3072 + i));
    bus.except = 1'b1;
    tick();
    drv_idle();
    chk("exc_wen", 64'(bus.write_wen), 64'd0);
    chk("exc_ready", 64'(bus.upd_ready), 64'd7);
    chk("exc_stall", 64'(bus.alloc_stall), 64'd0);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      drv_upd(i, 6'(24 + i), 64'(3328 + i));
      expect_wr(6'(24 + i), 64'(3328 + i));
    end
    tick();
    idle(5);

    // Simultaneous push and pop on requester 0 at count 1.
    drv_upd(0, 6'd44, 64'hB00);
    expect_wr(6'd44, 64'hB00);
    tick();
    drv_upd(0, 6'd45, 64'hB01);
    expect_wr(6'd45, 64'hB01);
    chk("pp_ready_pre", 64'(bus.upd_ready[0]), 64'd1);
    tick();
    drv_idle();
    chk("pp_ready_post", 64'(bus.upd_ready[0]), 64'd1);
    chk("pp_wen0", 64'(bus.write_wen), 64'd1);
    tick();
    chk("pp_wen1", 64'(bus.write_wen), 64'd1);
    idle(3);

    // Reset mid-operation discards a buffered update.
    drv_alloc(6'd9, 64'hC00);
    expect_wr(6'd9, 64'hC00);
    drv_upd(1, 6'd8, 64'hC01);
    tick();
    drv_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ready", 64'(bus.upd_ready), 64'd7);
    chk("rst2_wen", 64'(bus.write_wen), 64'd0);
    idle(5);

    chk("sb_left", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
